boa_mem_sram_resp: RTL and testbench

//  Responder (memory-side) end of the Boa³² data/instruction memory bus: a word-organised

---
 rtl/boa_mem_sram_resp.sv | 124 ++++++++++++
 tb/tb_boa_mem_sram_resp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/boa_mem_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : boa_mem_sram_resp
// Brief    : Boa32 memory-side bus responder: word SRAM, byte-lane writes,
//            configurable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module boa_mem_sram_resp #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_re,
  input  logic [3:0]  bus_we,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    req;
  logic                    hit;
  logic                    complete;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [31:0]             mem [DEPTH];

  assign req = bus_re || (|bus_we);
  assign idx = bus_addr[ADDR_WIDTH-1:0];

  generate
    if (ADDR_WIDTH >= 30) begin : g_full_window
      assign hit = 1'b1;
    end else begin : g_window
      assign hit = (bus_addr[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_ready = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!req) begin
          bus_ready = 1'b1;
        end else if (!hit || (WAIT_STATES == 0)) begin
          bus_ready = 1'b1;
          complete  = 1'b1;
        end else begin
          cnt_d   = C_WAIT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        bus_ready = (cnt_q == 4'd0);
        if (!req) begin
          // Initiator abandoned the request: discard the count, no side effects.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (rst) begin
      bus_ready = 1'b0;
      complete  = 1'b0;
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
    end

    // Old word is captured on the same edge a write lands: read-before-write.
    rdata_d = rdata_q;
    if (complete && bus_re) begin
      rdata_d = hit ? mem[idx] : 32'd0;
    end
    if (rst) begin
      rdata_d = 32'd0;
    end

    wr_en = complete && hit;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (wr_en && bus_we[n]) begin
        mem[idx][8*n +: 8] <= bus_wdata[8*n +: 8];
      end
    end
  end

  assign bus_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_boa_mem_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_boa_mem_sram_resp
// Brief    : Directed self-checking bench for boa_mem_sram_resp (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_boa_mem_sram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re    [3];
  logic [3:0]  we    [3];
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic        rdy   [3];
  logic [31:0] rdata [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 0: no wait states; 1: three wait states; 2: two wait states, window at 0x1000.
  boa_mem_sram_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus_re(re[0]), .bus_we(we[0]), .bus_addr(addr[0]),
    .bus_wdata(wdata[0]), .bus_ready(rdy[0]), .bus_rdata(rdata[0]));
  boa_mem_sram_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .bus_re(re[1]), .bus_we(we[1]), .bus_addr(addr[1]),
    .bus_wdata(wdata[1]), .bus_ready(rdy[1]), .bus_rdata(rdata[1]));
  boa_mem_sram_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .bus_re(re[2]), .bus_we(we[2]), .bus_addr(addr[2]),
    .bus_wdata(wdata[2]), .bus_ready(rdy[2]), .bus_rdata(rdata[2]));

  // Holds a request until ready is seen (bounded), records ready per cycle,
  // then releases it 1 time unit after the completion edge.
  task automatic txn(input int d, input logic r, input logic [3:0] w,
                     input logic [29:0] a, input logic [31:0] wd,
                     output int n, output logic [15:0] hist);
    re[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0; hist = '0;
    while (n < 16) begin
      @(negedge clk);
      hist[n] = rdy[d];
      n++;
      if (rdy[d]) break;
    end
    @(posedge clk); #1;
    re[d] = 1'b0; we[d] = 4'd0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (rdy[d] !== 1'b0) begin
          n_fail++; $display("FAIL reset_ready d=%0d got %b want 0", d, rdy[d]);
        end
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rdata[d] !== 32'd0) begin
        n_fail++; $display("FAIL reset_rdata d=%0d got %h want 0", d, rdata[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rdy[d] !== 1'b1) begin
        n_fail++; $display("FAIL idle_ready d=%0d got %b want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_basic();
    int n; logic [15:0] h;
    txn(0, 1'b0, 4'hF, 30'h004, 32'hDEADBEEF, n, h);
    n_cmp++;
    if (n !== 1) begin n_fail++; $display("FAIL basic_wr_cycles got %0d want 1", n); end
    txn(0, 1'b1, 4'h0, 30'h004, 32'h0, n, h);
    n_cmp++;
    if (n !== 1) begin n_fail++; $display("FAIL basic_rd_cycles got %0d want 1", n); end
    n_cmp++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rdata got %h want deadbeef", rdata[0]);
    end
  endtask

  task automatic test_byte_lanes();
    int n; logic [15:0] h;
    txn(0, 1'b0, 4'b1111, 30'h002, 32'h11223344, n, h);
    txn(0, 1'b0, 4'b0100, 30'h002, 32'hAAAAAAAA, n, h);
    txn(0, 1'b1, 4'b0000, 30'h002, 32'h0, n, h);
    n_cmp++;
    if (rdata[0] !== 32'h11AA3344) begin
      n_fail++; $display("FAIL lanes_rdata got %h want 11aa3344", rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [15:0] h;
    txn(0, 1'b0, 4'hF, 30'h010, 32'h01010101, n, h);
    txn(0, 1'b0, 4'hF, 30'h011, 32'h02020202, n, h);
    txn(0, 1'b1, 4'h0, 30'h010, 32'h0, n, h);
    n_cmp++;
    if (rdata[0] !== 32'h01010101) begin
      n_fail++; $display("FAIL b2b_rd0 got %h want 01010101", rdata[0]);
    end
    txn(0, 1'b1, 4'h0, 30'h011, 32'h0, n, h);
    n_cmp++;
    if (n !== 1 || rdata[0] !== 32'h02020202) begin
      n_fail++; $display("FAIL b2b_rd1 got n=%0d %h want n=1 02020202", n, rdata[0]);
    end
  endtask

  task automatic test_wait_states();
    int n; logic [15:0] h;
    txn(1, 1'b0, 4'hF, 30'h020, 32'hC0FFEE00, n, h);
    txn(1, 1'b1, 4'h0, 30'h020, 32'h0, n, h);
    n_cmp++;
    if (n !== 4 || h[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL ws3_ready got n=%0d hist=%b want n=4 hist=1000", n, h[3:0]);
    end
    n_cmp++;
    if (rdata[1] !== 32'hC0FFEE00) begin
      n_fail++; $display("FAIL ws3_rdata got %h want c0ffee00", rdata[1]);
    end
    txn(1, 1'b1, 4'h0, 30'h020, 32'h0, n, h);
    n_cmp++;
    if (n !== 4 || h[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL ws3_next_ready got n=%0d hist=%b want n=4 hist=1000", n, h[3:0]);
    end
  endtask

  task automatic test_abort();
    int n; logic [15:0] h;
    txn(2, 1'b0, 4'hF, 30'h401, 32'h55667788, n, h);
    n_cmp++;
    if (n !== 3) begin n_fail++; $display("FAIL ws2_cycles got %0d want 3", n); end
    re[2] = 1'b0; we[2] = 4'hF; addr[2] = 30'h401; wdata[2] = 32'hFFFFFFFF;
    @(negedge clk);
    n_cmp++;
    if (rdy[2] !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b want 0", rdy[2]); end
    @(posedge clk); #1; we[2] = 4'h0;
    @(posedge clk); #1;
    txn(2, 1'b1, 4'h0, 30'h401, 32'h0, n, h);
    n_cmp++;
    if (n !== 3 || rdata[2] !== 32'h55667788) begin
      n_fail++; $display("FAIL abort_rdata got n=%0d %h want n=3 55667788", n, rdata[2]);
    end
  endtask

  task automatic test_rbw();
    int n; logic [15:0] h;
    txn(0, 1'b0, 4'hF, 30'h008, 32'h0000CAFE, n, h);
    txn(0, 1'b1, 4'hF, 30'h008, 32'h12345678, n, h);
    n_cmp++;
    if (rdata[0] !== 32'h0000CAFE) begin
      n_fail++; $display("FAIL rbw_old got %h want 0000cafe", rdata[0]);
    end
    txn(0, 1'b1, 4'h0, 30'h008, 32'h0, n, h);
    n_cmp++;
    if (rdata[0] !== 32'h12345678) begin
      n_fail++; $display("FAIL rbw_new got %h want 12345678", rdata[0]);
    end
  endtask

  task automatic test_out_of_window();
    int n; logic [15:0] h;
    txn(2, 1'b0, 4'hF, 30'h400, 32'hA5A5A5A5, n, h);
    // Word 0 aliases the same SRAM index as 0x400 but lies outside the window.
    txn(2, 1'b0, 4'hF, 30'h000, 32'h12345678, n, h);
    n_cmp++;
    if (n !== 1) begin n_fail++; $display("FAIL oow_wr_cycles got %0d want 1", n); end
    txn(2, 1'b1, 4'h0, 30'h000, 32'h0, n, h);
    n_cmp++;
    if (n !== 1 || rdata[2] !== 32'd0) begin
      n_fail++; $display("FAIL oow_rd got n=%0d %h want n=1 0", n, rdata[2]);
    end
    txn(2, 1'b1, 4'h0, 30'h400, 32'h0, n, h);
    n_cmp++;
    if (rdata[2] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL oow_unchanged got %h want a5a5a5a5", rdata[2]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n; logic [15:0] h;
    re[2] = 1'b0; we[2] = 4'hF; addr[2] = 30'h400; wdata[2] = 32'hDEAD0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy[2] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready got %b want 0", rdy[2]); end
    @(posedge clk); #1;
    rst = 1'b0; we[2] = 4'h0;
    n_cmp++;
    if (rdata[2] !== 32'd0) begin n_fail++; $display("FAIL rst_wait_rdata got %h want 0", rdata[2]); end
    @(negedge clk);
    n_cmp++;
    if (rdy[2] !== 1'b1) begin n_fail++; $display("FAIL rst_idle_ready got %b want 1", rdy[2]); end
    @(posedge clk); #1;
    txn(2, 1'b1, 4'h0, 30'h400, 32'h0, n, h);
    n_cmp++;
    if (n !== 3 || rdata[2] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rst_nowrite got n=%0d %h want n=3 a5a5a5a5", n, rdata[2]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      re[d] = 1'b0; we[d] = 4'd0; addr[d] = 30'd0; wdata[d] = 32'd0;
    end
    test_reset();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_abort();
    test_rbw();
    test_out_of_window();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
